wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Writeback scheduler for the 2-write-port integer register file in the dual-issue core.
- Arbitrates up to NUM_REQ functional-unit results (default ALU0, ALU1, MUL, LSU) onto write ports 0/1 with round-robin fairness.
- Drives registered write-enable/address/data to the register file and matching scoreboard-clear pulses to the issue scoreboard.

Parameters:
- NUM_REQ, 4, number of result requesters (2..8)
- XLEN, 32, data width
- RW, 5, register address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  requester i holds a result
- req_rd  in  NUM_REQ*RW  destination register per requester (slice i)
- req_data  in  NUM_REQ*XLEN  result data per requester (slice i)
- req_ready  out  NUM_REQ  combinational grant; transfer when valid&&ready
- wb_hold  in  1  blocks all grants this cycle (debug/freeze)
- wen0, wen1  out  1  register-file write enables
- waddr0, waddr1  out  RW  write addresses
- wdata0, wdata1  out  XLEN  write data
- sb_clr0, sb_clr1  out  1  scoreboard busy-bit clear pulses
- sb_rd0, sb_rd1  out  RW  register to clear

Behaviour:
- Reset (async): wen0/1=0, waddr0/1=0, wdata0/1=0, sb_clr0/1=0, sb_rd0/1=0, rr_ptr=0. Outputs stay 0 while rst is high.
- Grant selection (combinational, same cycle):
  - Scan requesters in order rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - First valid requester found → slot 0. Next valid requester whose rd differs from slot 0's rd (or whose rd is 0) → slot 1.
  - A same-nonzero-rd requester is skipped this cycle and stays pending (no two writes to one register in a cycle).
  - At most 2 grants per cycle. req_ready[i]=1 only for granted i.
  - Requesters must hold valid/rd/data stable until granted.
- wb_hold=1: no grants; all req_ready=0; rr_ptr unchanged; outputs next cycle are wen=0, sb_clr=0.
- Latency: exactly 1 cycle. Slot s chosen in cycle N drives the following at posedge N+1, for one cycle:
  - wen_s=1, waddr_s=rd, wdata_s=data
  - sb_clr_s=1, sb_rd_s=rd
- rd==0: the request is granted and consumes its slot. wen_s=0, sb_clr_s=0, and waddr/wdata still latch (don't-care to the regfile).
- Unused slot: wen_s=0, sb_clr_s=0; waddr/wdata/sb_rd hold their previous values.
- Slot 1 is always the later requester in round-robin order, so the regfile's port-1-wins rule is never exercised by this block.
- rr_ptr update: after any grant, rr_ptr = (index of last granted slot + 1) mod NUM_REQ. No grant → unchanged.
- Fairness: a continuously valid requester is granted within ceil(NUM_REQ/2)+1 cycles, absent same-rd conflicts.
- Wrap-around: rr_ptr = NUM_REQ-1 scans index NUM_REQ-1, then 0, 1, ...
- Reset mid-operation: in-flight registered writes are dropped (wen forced 0). Requesters restart from rr_ptr=0.

Optional Feature:
- Macro WB_PERF_EN.
- Defined: adds output perf_conflict_cnt (32-bit) counting cycles where some req_valid was high, wb_hold=0, and fewer grants were issued than valid requests (port starvation or same-rd skip). Saturates at 0xFFFFFFFF; reset to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset, then req_valid=4'b0001, rd=5, data=0xA5A5A5A5 → req_ready=4'b0001 same cycle. Next cycle: wen0=1, waddr0=5, wdata0=0xA5A5A5A5, sb_clr0=1, sb_rd0=5, wen1=0. rr_ptr=1.
- All four valid, rd=1..4, ptr=0 → cycle 1 grants 0,1 (ptr→2); cycle 2 grants 2,3 (ptr→0). Writes appear on ports 0/1 one cycle after each grant.
- req 0 and req 1 both rd=7, req 2 rd=8, ptr=0 → grant 0 (slot 0) and 2 (slot 1); req 1 granted next cycle. Never wen0&&wen1 with waddr0==waddr1.
- req 3 rd=0 data=0x1234 alone → req_ready[3]=1; next cycle wen0=0, sb_clr0=0; ptr→0.
- wb_hold=1 with all valid for 3 cycles → req_ready=0, wen/sb_clr=0, ptr constant. Release → grants resume at saved ptr.
- Assert rst while wen0=1 pending → outputs 0 immediately. With WB_PERF_EN, the conflict scenario above increments perf_conflict_cnt by 1 and reset clears it to 0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: writeback scheduler for the two-write-port integer register file.
// Each cycle, up to two valid functional-unit results are picked in round-robin order.
// The picks become registered register-file writes and scoreboard-clear pulses one cycle later.
// Optional build macro WB_PERF_EN adds the perf_conflict_cnt output, a saturating counter
// of cycles in which valid results were left waiting.
module wb_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int XLEN    = 32,
    parameter int RW      = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*RW-1:0]   req_rd,
    input  logic [NUM_REQ*XLEN-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic                    wb_hold,
    output logic                    wen0,
    output logic                    wen1,
    output logic [RW-1:0]           waddr0,
    output logic [RW-1:0]           waddr1,
    output logic [XLEN-1:0]         wdata0,
    output logic [XLEN-1:0]         wdata1,
    output logic                    sb_clr0,
    output logic                    sb_clr1,
    output logic [RW-1:0]           sb_rd0,
    output logic [RW-1:0]           sb_rd1
`ifdef WB_PERF_EN
    ,
    output logic [31:0]             perf_conflict_cnt
`endif
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]   r_rrPtr;
    logic            r_wen0, r_wen1, r_clr0, r_clr1;
    logic [RW-1:0]   r_waddr0, r_waddr1, r_sbRd0, r_sbRd1;
    logic [XLEN-1:0] r_wdata0, r_wdata1;

    logic [RW-1:0]   w_rdArr   [NUM_REQ];
    logic [XLEN-1:0] w_dataArr [NUM_REQ];
    logic            w_found0, w_found1;
    logic [PW-1:0]   w_idx0, w_idx1, w_scanIdx, w_lastIdx;
    logic [PW:0]     w_sum;
    logic [RW-1:0]   w_rd0;
    logic [NUM_REQ-1:0] w_ready;

    // Split the flat request buses into per-requester slices.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_rdArr[g]   = req_rd[g*RW +: RW];
        assign w_dataArr[g] = req_data[g*XLEN +: XLEN];
    end

    // Round-robin scan from rr_ptr: first valid takes slot 0, next non-clashing valid takes slot 1.
    always_comb begin
        w_found0  = 1'b0;
        w_found1  = 1'b0;
        w_idx0    = '0;
        w_idx1    = '0;
        w_rd0     = '0;
        w_ready   = '0;
        w_sum     = '0;
        w_scanIdx = '0;
        if (!rst && !wb_hold) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_sum = {1'b0, r_rrPtr} + (PW+1)'(k);
                if (w_sum >= (PW+1)'(NUM_REQ)) begin
                    w_sum = w_sum - (PW+1)'(NUM_REQ);
                end
                w_scanIdx = w_sum[PW-1:0];
                if (req_valid[w_scanIdx]) begin
                    if (!w_found0) begin
                        w_found0           = 1'b1;
                        w_idx0             = w_scanIdx;
                        w_rd0              = w_rdArr[w_scanIdx];
                        w_ready[w_scanIdx] = 1'b1;
                    end else if (!w_found1 &&
                                 ((w_rdArr[w_scanIdx] != w_rd0) || (w_rdArr[w_scanIdx] == '0))) begin
                        w_found1           = 1'b1;
                        w_idx1             = w_scanIdx;
                        w_ready[w_scanIdx] = 1'b1;
                    end
                end
            end
        end
    end

    assign req_ready = w_ready;
    assign w_lastIdx = w_found1 ? w_idx1 : w_idx0;

    // Advance the round-robin pointer just past the last granted requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rrPtr <= '0;
        end else if (w_found0) begin
            if (w_lastIdx == PW'(NUM_REQ - 1)) begin
                r_rrPtr <= '0;
            end else begin
                r_rrPtr <= w_lastIdx + PW'(1);
            end
        end
    end

    // Register the chosen writes; rd==0 still latches address/data but raises no enable or clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wen0   <= 1'b0;
            r_wen1   <= 1'b0;
            r_clr0   <= 1'b0;
            r_clr1   <= 1'b0;
            r_waddr0 <= '0;
            r_waddr1 <= '0;
            r_wdata0 <= '0;
            r_wdata1 <= '0;
            r_sbRd0  <= '0;
            r_sbRd1  <= '0;
        end else begin
            r_wen0 <= 1'b0;
            r_wen1 <= 1'b0;
            r_clr0 <= 1'b0;
            r_clr1 <= 1'b0;
            if (w_found0) begin
                r_wen0   <= (w_rdArr[w_idx0] != '0);
                r_clr0   <= (w_rdArr[w_idx0] != '0);
                r_waddr0 <= w_rdArr[w_idx0];
                r_wdata0 <= w_dataArr[w_idx0];
                r_sbRd0  <= w_rdArr[w_idx0];
            end
            if (w_found1) begin
                r_wen1   <= (w_rdArr[w_idx1] != '0);
                r_clr1   <= (w_rdArr[w_idx1] != '0);
                r_waddr1 <= w_rdArr[w_idx1];
                r_wdata1 <= w_dataArr[w_idx1];
                r_sbRd1  <= w_rdArr[w_idx1];
            end
        end
    end

    assign wen0    = r_wen0;
    assign wen1    = r_wen1;
    assign sb_clr0 = r_clr0;
    assign sb_clr1 = r_clr1;
    assign waddr0  = r_waddr0;
    assign waddr1  = r_waddr1;
    assign wdata0  = r_wdata0;
    assign wdata1  = r_wdata1;
    assign sb_rd0  = r_sbRd0;
    assign sb_rd1  = r_sbRd1;

`ifdef WB_PERF_EN
    logic [3:0]  w_validCnt;
    logic [3:0]  w_grantCnt;
    logic        w_conflict;
    logic [31:0] r_perfCnt;

    // Compare how many results were waiting with how many were granted this cycle.
    always_comb begin
        w_validCnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_validCnt = w_validCnt + 4'(req_valid[i]);
        end
        w_grantCnt = 4'(w_found0) + 4'(w_found1);
        w_conflict = (|req_valid) && !wb_hold && (w_validCnt > w_grantCnt);
    end

    // Count starved cycles, holding at all ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perfCnt <= '0;
        end else if (w_conflict && (r_perfCnt != '1)) begin
            r_perfCnt <= r_perfCnt + 32'd1;
        end
    end

    assign perf_conflict_cnt = r_perfCnt;
`endif

endmodule
